eth_gmii_phy_rx: RTL and testbench

ETH_GMII_PHY_RX -- requirements
Module: eth_gmii_phy_rx

---
 rtl/eth_gmii_pkg.sv | 32 +++
 rtl/eth_crc32_d8.sv | 24 ++
 rtl/eth_gmii_phy_rx.sv | 211 +++++++++++++++++++++
 tb/tb_eth_gmii_phy_rx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_gmii_pkg.sv
// Shared definitions for the GMII receive path.
// Holds the receive state encoding, the framing byte values, the CRC-32
// constants and a saturating-counter helper used by eth_gmii_phy_rx.
package eth_gmii_pkg;

  typedef enum logic [1:0] {
    ST_DROP     = 2'd0,
    ST_IDLE     = 2'd1,
    ST_PREAMBLE = 2'd2,
    ST_DATA     = 2'd3
  } rx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  // Register value left after running a frame plus its own correct FCS
  // through the CRC without the final inversion.
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
  // 0x04C11DB7 bit-reversed, for the LSB-first (reflected) update.
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

  // The four FCS bytes plus the byte waiting to be known as "last".
  localparam int          DELAY_DEPTH   = 5;
  localparam logic [10:0] LEN_SAT       = 11'd2047;
  localparam logic [15:0] CNT_SAT       = 16'hFFFF;

  function automatic logic [15:0] sat_inc(input logic [15:0] value, input logic en);
    return (en && value != CNT_SAT) ? value + 16'd1 : value;
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// One-byte step of the reflected Ethernet CRC-32, purely combinational.
// Ports:
//   crc_in  - current CRC register
//   data    - byte entering the CRC, LSB first on the wire
//   crc_out - CRC register after absorbing the byte (no final inversion)
module eth_crc32_d8
  import eth_gmii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] crc_work;

  always_comb begin
    crc_work = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      crc_work = crc_work[0] ? ((crc_work >> 1) ^ CRC_POLY_REFL) : (crc_work >> 1);
    end
    crc_out = crc_work;
  end

endmodule

// File: rtl/eth_gmii_phy_rx.sv
// GMII receive side: turns a MAC-driven GMII byte stream into an AXI-Stream
// of payload bytes with the FCS stripped and a bad-frame flag on the last byte.
// The last four bytes of a frame are only known to be FCS once tx_en drops, so
// every byte sits in a 5-deep delay line before it may be emitted.
// Ports:
//   clock125, reset_n             - 125 MHz clock, async active-low reset
//   gmii_txd/tx_en/tx_er          - GMII byte, enable and error from the MAC
//   rx_axis_tdata/tvalid/tready   - payload stream (single output register)
//   rx_axis_tlast/tuser           - end of frame / frame bad (valid with tlast)
//   frames_good/bad/dropped       - saturating 16-bit event counters
module eth_gmii_phy_rx
  import eth_gmii_pkg::*;
#(
  parameter int MIN_FRAME_LENGTH = 64,
  parameter int MAX_FRAME_LENGTH = 1522
) (
  input  logic        clock125,
  input  logic        reset_n,
  input  logic [7:0]  gmii_txd,
  input  logic        gmii_tx_en,
  input  logic        gmii_tx_er,
  output logic [7:0]  rx_axis_tdata,
  output logic        rx_axis_tvalid,
  input  logic        rx_axis_tready,
  output logic        rx_axis_tlast,
  output logic        rx_axis_tuser,
  output logic [15:0] frames_good,
  output logic [15:0] frames_bad,
  output logic [15:0] frames_dropped
);

  localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME_LENGTH);
  localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_LENGTH);

  rx_state_e                     state_q, state_d;
  logic [2:0]                    pre_cnt_q, pre_cnt_d;
  logic [31:0]                   crc_q, crc_d, crc_next;
  logic [10:0]                   len_q, len_d;
  logic                          err_q, err_d;
  logic [DELAY_DEPTH-1:0][7:0]   line_q, line_d;   // [0] newest, [DELAY_DEPTH-1] oldest
  logic [7:0]                    out_data_q, out_data_d;
  logic                          out_valid_q, out_valid_d;
  logic                          out_last_q, out_last_d;
  logic                          out_user_q, out_user_d;
  logic [15:0]                   frames_good_q, frames_good_d;
  logic [15:0]                   frames_bad_q, frames_bad_d;
  logic [15:0]                   frames_dropped_q, frames_dropped_d;

  logic inc_good, inc_bad, inc_drop;
  logic load, load_last, load_user;
  logic out_free, line_full, frame_bad;

  eth_crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    (gmii_txd),
    .crc_out (crc_next)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; that is what keeps this block free of inferred latches.
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    crc_d       = crc_q;
    len_d       = len_q;
    err_d       = err_q;
    line_d      = line_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_user_d  = out_user_q;
    inc_good    = 1'b0;
    inc_bad     = 1'b0;
    inc_drop    = 1'b0;
    load        = 1'b0;
    load_last   = 1'b0;
    load_user   = 1'b0;

    // The output register can take a new byte if empty or being drained now.
    out_free  = !out_valid_q || rx_axis_tready;
    if (out_valid_q && rx_axis_tready) out_valid_d = 1'b0;

    line_full = (len_q >= 11'(DELAY_DEPTH));
    frame_bad = err_q || (crc_q != CRC_RESIDUE) || (len_q < MIN_LEN) || (len_q > MAX_LEN);

    case (state_q)
      ST_DROP: begin
        if (!gmii_tx_en) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (gmii_tx_en) begin
          if (gmii_txd == PREAMBLE_BYTE) begin
            state_d   = ST_PREAMBLE;
            pre_cnt_d = 3'd1;
          end else begin
            state_d  = ST_DROP;
            inc_drop = 1'b1;
          end
        end
      end
      ST_PREAMBLE: begin
        if (!gmii_tx_en) begin
          state_d  = ST_IDLE;
          inc_drop = 1'b1;
        end else if (gmii_txd == PREAMBLE_BYTE) begin
          // Seven preamble bytes is the legal maximum; an eighth is garbage.
          if (pre_cnt_q == 3'd7) begin
            state_d  = ST_DROP;
            inc_drop = 1'b1;
          end else begin
            pre_cnt_d = pre_cnt_q + 3'd1;
          end
        end else if (gmii_txd == SFD_BYTE) begin
          state_d = ST_DATA;
          crc_d   = CRC_INIT;
          len_d   = 11'd0;
          err_d   = 1'b0;
        end else begin
          state_d  = ST_DROP;
          inc_drop = 1'b1;
        end
      end
      ST_DATA: begin
        if (gmii_tx_en) begin
          line_d = {line_q[DELAY_DEPTH-2:0], gmii_txd};
          crc_d  = crc_next;
          len_d  = (len_q == LEN_SAT) ? len_q : len_q + 11'd1;
          if (gmii_tx_er) err_d = 1'b1;
          if (line_full) load = 1'b1;
        end else begin
          state_d = ST_IDLE;
          if (!line_full) begin
            inc_drop = 1'b1;
          end else begin
            load      = 1'b1;
            load_last = 1'b1;
            load_user = frame_bad;
          end
        end
      end
      default: state_d = ST_DROP;
    endcase

    if (load) begin
      if (out_free) begin
        out_data_d  = line_q[DELAY_DEPTH-1];
        out_valid_d = 1'b1;
        out_last_d  = load_last;
        out_user_d  = load_user;
        inc_good    = load_last && !load_user;
        inc_bad     = load_last && load_user;
      end else begin
        // Overflow: the stalled byte becomes the truncated end of a bad frame
        // and the rest of the frame is discarded.
        out_last_d = 1'b1;
        out_user_d = 1'b1;
        inc_bad    = 1'b1;
        state_d    = ST_DROP;
      end
    end

    frames_good_d    = sat_inc(frames_good_q, inc_good);
    frames_bad_d     = sat_inc(frames_bad_q, inc_bad);
    frames_dropped_d = sat_inc(frames_dropped_q, inc_drop);
  end

  // NOTE: the delay line is plain flops and takes the reset like everything
  // else, so no byte from before a reset can ever reach the output.
  always_ff @(posedge clock125 or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_DROP;
      pre_cnt_q        <= 3'd0;
      crc_q            <= CRC_INIT;
      len_q            <= 11'd0;
      err_q            <= 1'b0;
      line_q           <= '0;
      out_data_q       <= 8'h00;
      out_valid_q      <= 1'b0;
      out_last_q       <= 1'b0;
      out_user_q       <= 1'b0;
      frames_good_q    <= 16'h0000;
      frames_bad_q     <= 16'h0000;
      frames_dropped_q <= 16'h0000;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // computed from the previous state, independent of statement order.
      state_q          <= state_d;
      pre_cnt_q        <= pre_cnt_d;
      crc_q            <= crc_d;
      len_q            <= len_d;
      err_q            <= err_d;
      line_q           <= line_d;
      out_data_q       <= out_data_d;
      out_valid_q      <= out_valid_d;
      out_last_q       <= out_last_d;
      out_user_q       <= out_user_d;
      frames_good_q    <= frames_good_d;
      frames_bad_q     <= frames_bad_d;
      frames_dropped_q <= frames_dropped_d;
    end
  end

  assign rx_axis_tdata  = out_data_q;
  assign rx_axis_tvalid = out_valid_q;
  assign rx_axis_tlast  = out_last_q;
  assign rx_axis_tuser  = out_user_q;
  assign frames_good    = frames_good_q;
  assign frames_bad     = frames_bad_q;
  assign frames_dropped = frames_dropped_q;

endmodule

// File: tb/tb_eth_gmii_phy_rx.sv
// Directed bench for eth_gmii_phy_rx: builds GMII frames with a
// standard Ethernet FCS, collects the AXI-Stream output and compares
// against the payload that was sent and hand-tracked counter values.
module tb_eth_gmii_phy_rx;

  logic        clock125;
  logic        reset_n;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en;
  logic        gmii_tx_er;
  logic [7:0]  rx_axis_tdata;
  logic        rx_axis_tvalid;
  logic        rx_axis_tready;
  logic        rx_axis_tlast;
  logic        rx_axis_tuser;
  logic [15:0] frames_good;
  logic [15:0] frames_bad;
  logic [15:0] frames_dropped;

  int total = 0;
  int bad   = 0;
  int cyc_cnt = 0;
  int first_v = -1;
  int e0 = -1;

  logic [7:0] frm[$];
  logic [7:0] exp_pl[$];
  logic [7:0] rx_data[$];
  logic       rx_last[$];
  logic       rx_user[$];

  eth_gmii_phy_rx dut (
    .clock125       (clock125),
    .reset_n        (reset_n),
    .gmii_txd       (gmii_txd),
    .gmii_tx_en     (gmii_tx_en),
    .gmii_tx_er     (gmii_tx_er),
    .rx_axis_tdata  (rx_axis_tdata),
    .rx_axis_tvalid (rx_axis_tvalid),
    .rx_axis_tready (rx_axis_tready),
    .rx_axis_tlast  (rx_axis_tlast),
    .rx_axis_tuser  (rx_axis_tuser),
    .frames_good    (frames_good),
    .frames_bad     (frames_bad),
    .frames_dropped (frames_dropped)
  );

  initial clock125 = 1'b0;
  always #4 clock125 = ~clock125;

  always @(posedge clock125) cyc_cnt <= cyc_cnt + 1;

  // A byte shown with tvalid and tready at the falling edge is taken at the next rising edge.
  always @(negedge clock125) begin
    if (reset_n && rx_axis_tvalid && rx_axis_tready) begin
      rx_data.push_back(rx_axis_tdata);
      rx_last.push_back(rx_axis_tlast);
      rx_user.push_back(rx_axis_tuser);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock125);
    #1;
    if (e0 >= 0 && first_v < 0 && rx_axis_tvalid) first_v = cyc_cnt;
  endtask

  // Standard Ethernet FCS: reflected CRC-32, init all ones, final inversion.
  function automatic logic [31:0] fcs_of_payload();
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int i = 0; i < exp_pl.size(); i++) begin
      c = c ^ {24'h0, exp_pl[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build(input int n_pre, input int n_pl, input int seed,
                       input int flip_at, input bit with_fcs);
    logic [31:0] c;
    frm.delete();
    exp_pl.delete();
    for (int i = 0; i < n_pre; i++) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    for (int i = 0; i < n_pl; i++) exp_pl.push_back(8'(seed + i * 13));
    c = fcs_of_payload();
    if (flip_at >= 0) exp_pl[flip_at] = exp_pl[flip_at] ^ 8'h04;
    for (int i = 0; i < n_pl; i++) frm.push_back(exp_pl[i]);
    if (with_fcs) begin
      frm.push_back(c[7:0]);
      frm.push_back(c[15:8]);
      frm.push_back(c[23:16]);
      frm.push_back(c[31:24]);
    end
  endtask

  // Drives frm then an idle gap. rst_at/er_at/hold_at < 0 disables that action.
  task automatic send(input int rst_at, input int er_at, input int hold_at, input int lat_at);
    for (int i = 0; i < frm.size(); i++) begin
      if (i == rst_at) begin
        reset_n = 1'b0;
        #2;
        check("midrst tvalid", 32'(rx_axis_tvalid), 32'd0);
        check("midrst tdata", 32'(rx_axis_tdata), 32'd0);
        check("midrst good", 32'(frames_good), 32'd0);
        check("midrst bad", 32'(frames_bad), 32'd0);
        check("midrst dropped", 32'(frames_dropped), 32'd0);
        reset_n = 1'b1;
        rx_data.delete();
        rx_last.delete();
        rx_user.delete();
      end
      gmii_tx_en = 1'b1;
      gmii_txd   = frm[i];
      gmii_tx_er = (i == er_at);
      if (hold_at >= 0) rx_axis_tready = (rx_data.size() < hold_at);
      step();
      if (i == lat_at) e0 = cyc_cnt;
    end
    gmii_tx_en = 1'b0;
    gmii_tx_er = 1'b0;
    gmii_txd   = 8'h00;
    repeat (12) step();
  endtask

  task automatic check_rx(input string tag, input int exp_n, input logic exp_user);
    int errs;
    int n;
    errs = 0;
    n = rx_data.size();
    check({tag, " count"}, 32'(n), 32'(exp_n));
    if (exp_n > 0 && n == exp_n) begin
      for (int i = 0; i < n; i++) begin
        if (rx_data[i] !== exp_pl[i]) errs++;
        if (rx_last[i] !== (i == n - 1)) errs++;
        if (i < n - 1 && rx_user[i] !== 1'b0) errs++;
      end
      check({tag, " data/tlast"}, 32'(errs), 32'd0);
      check({tag, " tuser"}, 32'(rx_user[n-1]), 32'(exp_user));
    end
    rx_data.delete();
    rx_last.delete();
    rx_user.delete();
  endtask

  initial begin
    reset_n        = 1'b0;
    gmii_txd       = 8'h00;
    gmii_tx_en     = 1'b0;
    gmii_tx_er     = 1'b0;
    rx_axis_tready = 1'b1;
    repeat (3) step();
    check("rst tvalid", 32'(rx_axis_tvalid), 32'd0);
    check("rst tlast", 32'(rx_axis_tlast), 32'd0);
    check("rst tuser", 32'(rx_axis_tuser), 32'd0);
    check("rst tdata", 32'(rx_axis_tdata), 32'd0);
    check("rst good", 32'(frames_good), 32'd0);
    check("rst bad", 32'(frames_bad), 32'd0);
    check("rst dropped", 32'(frames_dropped), 32'd0);
    reset_n = 1'b1;
    repeat (4) step();

    // Good 64-byte frame; first payload byte (frame index 8) is loaded into
    // the output register on the sixth edge counting its sampling edge.
    build(7, 60, 8'h11, -1, 1'b1);
    send(-1, -1, -1, 8);
    check("latency edges", 32'(first_v - e0), 32'd5);
    e0 = -1;
    check_rx("good", 60, 1'b0);
    check("good frames_good", 32'(frames_good), 32'd1);

    // Same frame with one payload bit flipped: CRC fails.
    build(7, 60, 8'h11, 17, 1'b1);
    send(-1, -1, -1, -1);
    check_rx("crcerr", 60, 1'b1);
    check("crcerr frames_bad", 32'(frames_bad), 32'd1);

    // Runt: 20 payload + FCS = 24 bytes, under the 64-byte minimum.
    build(7, 20, 8'h3C, -1, 1'b1);
    send(-1, -1, -1, -1);
    check_rx("runt", 20, 1'b1);
    check("runt frames_bad", 32'(frames_bad), 32'd2);

    // 0x55, 0xD5, three bytes: too short to emit anything.
    build(1, 3, 8'h70, -1, 1'b0);
    send(-1, -1, -1, -1);
    check_rx("short", 0, 1'b0);
    check("short frames_dropped", 32'(frames_dropped), 32'd1);

    // Eight preamble bytes: dropped at the eighth, rest of frame ignored.
    build(8, 60, 8'h22, -1, 1'b1);
    send(-1, -1, -1, -1);
    check_rx("longpre", 0, 1'b0);
    check("longpre frames_dropped", 32'(frames_dropped), 32'd2);

    // Overflow: tready drops once nine bytes are taken; byte 10 stays held.
    build(7, 60, 8'h5A, -1, 1'b1);
    send(-1, -1, 9, -1);
    check("ovf tvalid", 32'(rx_axis_tvalid), 32'd1);
    check("ovf tdata", 32'(rx_axis_tdata), 32'(exp_pl[9]));
    check("ovf tlast", 32'(rx_axis_tlast), 32'd1);
    check("ovf tuser", 32'(rx_axis_tuser), 32'd1);
    check("ovf frames_bad", 32'(frames_bad), 32'd3);
    check("ovf frames_good", 32'(frames_good), 32'd1);
    check("ovf frames_dropped", 32'(frames_dropped), 32'd2);
    rx_axis_tready = 1'b1;
    repeat (3) step();
    check_rx("ovf", 10, 1'b1);
    build(7, 60, 8'h11, -1, 1'b1);
    send(-1, -1, -1, -1);
    check_rx("after ovf", 60, 1'b0);
    check("after ovf frames_good", 32'(frames_good), 32'd2);

    // Reset pulse at payload byte 30 (frame index 8 + 29).
    build(7, 60, 8'h44, -1, 1'b1);
    send(37, -1, -1, -1);
    check_rx("midrst rest", 0, 1'b0);
    build(7, 60, 8'h11, -1, 1'b1);
    send(-1, -1, -1, -1);
    check_rx("post rst", 60, 1'b0);
    check("post rst frames_good", 32'(frames_good), 32'd1);

    // tx_er on payload byte 40 (frame index 8 + 39).
    build(7, 60, 8'h11, -1, 1'b1);
    send(-1, 47, -1, -1);
    check_rx("txer", 60, 1'b1);
    check("txer frames_bad", 32'(frames_bad), 32'd1);

    // Saturation: preload the good counter just under the limit.
    force dut.frames_good_q = 16'hFFFE;
    step();
    release dut.frames_good_q;
    step();
    check("sat preload", 32'(frames_good), 32'h0000_FFFE);
    build(7, 60, 8'h11, -1, 1'b1);
    send(-1, -1, -1, -1);
    check_rx("sat1", 60, 1'b0);
    check("sat1 frames_good", 32'(frames_good), 32'h0000_FFFF);
    build(7, 60, 8'h11, -1, 1'b1);
    send(-1, -1, -1, -1);
    check_rx("sat2", 60, 1'b0);
    check("sat2 frames_good", 32'(frames_good), 32'h0000_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
